// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    localparam int REG_ZERO       = 0;
    localparam int MD_LATENCY_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use, taken-branch and mult/div hazard control
// for the 5-stage pipeline front end, with stall/flush performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_md_start,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    hz_state_e  state_d;
    hz_state_e  state_q;
    logic [3:0] md_cnt_d;
    logic [3:0] md_cnt_q;
    logic       lu;

    // Writes to register zero never create a real dependency.
    assign lu = ex_mem_read
             && (ex_rd != REG_W'(REG_ZERO))
             && ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (id_md_start && !lu && !ex_branch_taken) begin
                    state_d  = MD_WAIT;
                    md_cnt_d = 4'(MD_LATENCY - 1);
                end
            end
            MD_WAIT: begin
                if (ex_branch_taken || (md_cnt_q == 4'd0)) begin
                    state_d  = RUN;
                    md_cnt_d = 4'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Reset is folded in combinationally so the controls go safe without waiting for a clock.
    always_comb begin
        pc_write     = 1'b1;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if ((state_q == MD_WAIT) || lu) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign md_busy = (state_q == MD_WAIT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_stall),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_flush && reset),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int REG_W      = 5;
    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_md_start;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             pc_write;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(
        .REG_W      (REG_W),
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_md_start     (id_md_start),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input int pc, input int st, input int fl, input int bb);
        check({tag, ".pc_write"}, pc_write, pc);
        check({tag, ".if_id_stall"}, if_id_stall, st);
        check({tag, ".if_id_flush"}, if_id_flush, fl);
        check({tag, ".id_ex_bubble"}, id_ex_bubble, bb);
    endtask

    task automatic set_idle();
        id_rs           = 5'd1;
        id_rt           = 5'd2;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        id_md_start     = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rd           = 5'd3;
        ex_branch_taken = 1'b0;
    endtask

    task automatic set_lu_rs8();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd8;
        id_rs       = 5'd8;
        id_uses_rs  = 1'b1;
    endtask

    // Advance to 1 time unit after the next posedge; inputs are changed there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        #2;
        check_ctrl("rst", 0, 0, 1, 1);
        check("rst.md_busy", md_busy, 0);
        check("rst.stall_cycles", stall_cycles, 0);
        check("rst.flush_events", flush_events, 0);
        tick(); tick(); tick();
        check_ctrl("rst3", 0, 0, 1, 1);
        reset = 1'b1;
        #2;
        check_ctrl("run", 1, 0, 0, 0);
        tick();
        check("run.stall_cycles", stall_cycles, 0);
        check("run.flush_events", flush_events, 0);

        // load-use on rs
        set_lu_rs8();
        #2;
        check_ctrl("lu_rs", 0, 1, 0, 1);
        tick();
        set_idle();
        #2;
        check_ctrl("lu_after", 1, 0, 0, 0);
        check("lu.stall_cycles", stall_cycles, 1);

        // load-use on rt
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        #2;
        check_ctrl("lu_rt", 0, 1, 0, 1);
        tick();
        set_idle();
        check("lu_rt.stall_cycles", stall_cycles, 2);

        // register zero never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #2;
        check_ctrl("reg0", 1, 0, 0, 0);
        tick();
        // matching rt that is not read
        set_idle();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b0;
        id_rs = 5'd3; id_uses_rs = 1'b1;
        #2;
        check_ctrl("unused_rt", 1, 0, 0, 0);
        tick();
        set_idle();
        check("nostall.stall_cycles", stall_cycles, 2);

        // taken branch beats load-use
        set_lu_rs8();
        ex_branch_taken = 1'b1;
        #2;
        check_ctrl("br_lu", 1, 0, 1, 1);
        tick();
        set_idle();
        check("br.flush_events", flush_events, 1);
        check("br.stall_cycles", stall_cycles, 2);

        // full mult/div occupancy
        id_md_start = 1'b1;
        #2;
        check_ctrl("md_c0", 1, 0, 0, 0);
        check("md_c0.md_busy", md_busy, 0);
        tick();
        set_idle();
        for (int c = 1; c <= 4; c++) begin
            #2;
            check($sformatf("md_c%0d.md_busy", c), md_busy, 1);
            check_ctrl($sformatf("md_c%0d", c), 0, 1, 0, 1);
            tick();
        end
        #2;
        check("md_c5.md_busy", md_busy, 0);
        check_ctrl("md_c5", 1, 0, 0, 0);
        check("md.stall_cycles", stall_cycles, 6);

        // mult/div aborted by a taken branch in cycle 2
        id_md_start = 1'b1;
        tick();
        set_idle();
        #2;
        check("ab_c1.md_busy", md_busy, 1);
        tick();
        ex_branch_taken = 1'b1;
        #2;
        check_ctrl("ab_c2", 1, 0, 1, 1);
        tick();
        set_idle();
        #2;
        check("ab_c3.md_busy", md_busy, 0);
        check_ctrl("ab_c3", 1, 0, 0, 0);
        check("ab.stall_cycles", stall_cycles, 7);
        check("ab.flush_events", flush_events, 2);

        // mult/div behind a load-use waits; it does not enter MD_WAIT
        set_lu_rs8();
        id_md_start = 1'b1;
        tick();
        set_idle();
        #2;
        check("mdlu.md_busy", md_busy, 0);
        check("mdlu.stall_cycles", stall_cycles, 8);

        // reset in the middle of MD_WAIT
        tick();
        id_md_start = 1'b1;
        tick();
        set_idle();
        tick();
        #2;
        check("mdrst.pre_busy", md_busy, 1);
        reset = 1'b0;
        #1;
        check("mdrst.md_busy", md_busy, 0);
        check("mdrst.stall_cycles", stall_cycles, 0);
        check("mdrst.flush_events", flush_events, 0);
        check_ctrl("mdrst", 0, 0, 1, 1);
        tick();
        reset = 1'b1;
        tick();
        check("mdrst.flush_after", flush_events, 0);

        // saturation at CNT_W=4
        set_lu_rs8();
        for (int i = 0; i < 15; i++) tick();
        check("sat15.stall_cycles", stall_cycles, 15);
        for (int i = 0; i < 5; i++) tick();
        check("sat20.stall_cycles", stall_cycles, 15);
        check_ctrl("sat", 0, 1, 0, 1);
        set_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It generates `pc_write`, `if_id_stall`, `if_id_flush` and `id_ex_bubble` for the PC, the IF/ID register and the ID/EX register. It detects load-use hazards, taken-branch flushes and fixed-latency multiply/divide occupancy, and keeps saturating stall and flush event counters for performance debug.

## Interface
- `REG_W`, 5: register-specifier width.
- `MD_LATENCY`, 4: cycles the front end is frozen after a mult/div leaves ID; legal range 1..15.
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1: pipeline clock. State updates on posedge; IF/ID captures on negedge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `id_rs`, `id_rt`  in  REG_W: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1: ID instruction actually reads rs / rt.
- `id_md_start`  in  1: ID instruction is a mult/div.
- `ex_mem_read`  in  1: EX instruction is a load.
- `ex_rd`  in  REG_W: destination register of the EX instruction.
- `ex_branch_taken`  in  1: branch/jump resolved taken in EX.
- `pc_write`  out  1: PC update enable.
- `if_id_stall`  out  1: hold IF/ID.
- `if_id_flush`  out  1: zero IF/ID (NOP, PC 0).
- `id_ex_bubble`  out  1: load a NOP into ID/EX.
- `md_busy`  out  1: FSM is in MD_WAIT.
- `stall_cycles`  out  CNT_W: cycles with `if_id_stall`=1, saturating.
- `flush_events`  out  CNT_W: cycles with `if_id_flush`=1 outside reset, saturating.

## Operation
- FSM states: RUN and MD_WAIT. A down-counter `md_cnt` is 4 bits wide.
- Load-use hazard `lu` is true when all of these hold:
  - `ex_mem_read`
  - `ex_rd`≠0
  - (`id_uses_rs` and `id_rs`==`ex_rd`) or (`id_uses_rt` and `id_rt`==`ex_rd`)
- Output priority, highest first:
  1. Reset asserted: `pc_write`=0, `if_id_stall`=0, `if_id_flush`=1, `id_ex_bubble`=1.
  2. `ex_branch_taken`: `pc_write`=1, `if_id_flush`=1, `id_ex_bubble`=1, `if_id_stall`=0. This applies in either state. In MD_WAIT the FSM goes to RUN at the next posedge (abort).
  3. MD_WAIT: `pc_write`=0, `if_id_stall`=1, `id_ex_bubble`=1.
  4. RUN and `lu`: `pc_write`=0, `if_id_stall`=1, `id_ex_bubble`=1.
  5. Otherwise: `pc_write`=1 and all other controls 0.
- RUN to MD_WAIT happens when `id_md_start`, not `lu`, and not `ex_branch_taken`. On entry `md_cnt` loads MD_LATENCY-1. The mult/div itself advances to EX that cycle.
- In MD_WAIT: if `md_cnt`==0 go to RUN, else decrement. MD_WAIT therefore lasts exactly MD_LATENCY cycles.
- `stall_cycles` and `flush_events` increment on posedge when their condition holds. They hold at all-ones and never wrap.
- `if_id_flush` and `if_id_stall` are never both 1.

## Timing
- Control outputs are combinational from the current state and inputs. They are valid before the negedge of the same cycle.
- State, `md_cnt` and the counters update on posedge clk.
- Reset values: state RUN, `md_cnt` 0, `md_busy` 0, counters 0. Control outputs take the reset values in priority 1 immediately and asynchronously.
- Load-use penalty: exactly 1 stall cycle. The hazard clears by itself next cycle because EX then holds the bubble.
- Taken-branch penalty: 1 flushed IF/ID slot, with ID/EX bubbled in the same cycle.
- Mult/div penalty: MD_LATENCY frozen cycles after the issue cycle.
- Reset mid-MD_WAIT: FSM returns to RUN and the counters clear.
- Deassertion of reset takes effect at the next posedge.

## Structure
- Package `hazard_pkg` holds:
  - the FSM state type {RUN, MD_WAIT}
  - `REG_ZERO` = 0
  - the default for `MD_LATENCY`
- Sub-module `sat_counter` (param WIDTH; ports clk, reset, inc, count) is instantiated twice, once per counter.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release. During reset `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=0. After release all counters are 0 and `pc_write`=1.
- Load-use: `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1 for one cycle.
  - That cycle: `pc_write`=0, `if_id_stall`=1, `id_ex_bubble`=1.
  - Next cycle, with `ex_mem_read`=0: normal operation.
  - `stall_cycles`=1.
- Register-zero and unused source: `ex_rd`=0 with a matching `id_rs`, or a match with `id_uses_rt`=0. Either case gives no stall.
- Branch beats load-use: `ex_branch_taken`=1 with a load-use match. Result: `if_id_flush`=1, `if_id_stall`=0, `pc_write`=1, `flush_events` increments by 1.
- Mult/div, MD_LATENCY=4: `id_md_start`=1 in cycle 0.
  - `md_busy`=1 and the front end is frozen for cycles 1-4.
  - RUN resumes in cycle 5.
  - `stall_cycles`=4.
  - `ex_branch_taken`=1 in cycle 2 aborts to RUN in cycle 3.
- Saturation (CNT_W=4): hold a stall condition for 20 cycles. `stall_cycles` stays at 15.
